// File: rtl/mem_link_arbiter_pkg.sv
// Shared constants and FSM encoding for the two-requester cache->memory link arbiter.
package mem_link_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W   = 10;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_TIMEOUT  = 64;
  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitTx,
    StWaitResp,
    StDone
  } state_e;

  // A requester is active when it raises either read or write.
  function automatic logic req_active(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/mem_link_arbiter_if.sv
// Bundle of requester, sender-link and receiver-link signals around the arbiter.
interface mem_link_arbiter_if
  import mem_link_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  logic              req0_read;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_done;
  logic [DATA_W-1:0] req0_rdata;
  logic              req0_err;

  logic              req1_read;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_done;
  logic [DATA_W-1:0] req1_rdata;
  logic              req1_err;

  logic              send;
  logic              link_write;
  logic [ADDR_W-1:0] link_addr;
  logic [DATA_W-1:0] link_wdata;
  logic              done_sender;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              busy;

  // Requesters plus link endpoints.
  modport master (
    output req0_read, req0_write, req0_addr, req0_wdata,
    output req1_read, req1_write, req1_addr, req1_wdata,
    output done_sender, resp_valid, resp_data,
    input  req0_done, req0_rdata, req0_err,
    input  req1_done, req1_rdata, req1_err,
    input  send, link_write, link_addr, link_wdata, busy
  );

  // The arbiter itself.
  modport slave (
    input  req0_read, req0_write, req0_addr, req0_wdata,
    input  req1_read, req1_write, req1_addr, req1_wdata,
    input  done_sender, resp_valid, resp_data,
    output req0_done, req0_rdata, req0_err,
    output req1_done, req1_rdata, req1_err,
    output send, link_write, link_addr, link_wdata, busy
  );

endinterface

// File: rtl/mem_link_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to ptr.
module mem_link_arbiter_rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt,
  output logic       valid
);

  always_comb begin
    valid = |req;
    gnt   = (req == 2'b11) ? ptr : req[1];
  end

endmodule

// File: rtl/mem_link_arbiter.sv
// Shares one sender/receiver link pair between two requesters, one transaction at a time.
module mem_link_arbiter
  import mem_link_arbiter_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter int unsigned       DATA_W   = DEF_DATA_W,
  parameter int unsigned       TIMEOUT  = DEF_TIMEOUT,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEF_ERR_DATA)
) (
  input logic               clock,
  input logic               reset,
  mem_link_arbiter_if.slave bus
);

  localparam int unsigned       CTR_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CTR_W-1:0]  CTR_MAX = CTR_W'(TIMEOUT - 1);

  state_e            state_q;
  logic              rr_ptr_q;
  logic              gnt_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CTR_W-1:0]  ctr_q;
  logic              send_q;
  logic [1:0]        done_q;
  logic [1:0]        err_q;
  logic [DATA_W-1:0] rdata_q [2];

  logic [1:0]        req_act;
  logic              arb_gnt;
  logic              arb_valid;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req_act = {req_active(bus.req1_read, bus.req1_write),
                    req_active(bus.req0_read, bus.req0_write)};

  mem_link_arbiter_rr_arb2 u_rr_arb2 (
    .req   (req_act),
    .ptr   (rr_ptr_q),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  // Write takes precedence when a requester raises both read and write.
  always_comb begin
    sel_write = arb_gnt ? bus.req1_write : bus.req0_write;
    sel_addr  = arb_gnt ? bus.req1_addr  : bus.req0_addr;
    sel_wdata = arb_gnt ? bus.req1_wdata : bus.req0_wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      rr_ptr_q   <= 1'b0;
      gnt_q      <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ctr_q      <= '0;
      send_q     <= 1'b0;
      done_q     <= 2'b00;
      err_q      <= 2'b00;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      send_q <= 1'b0;
      done_q <= 2'b00;
      unique case (state_q)
        StIdle: begin
          if (arb_valid) begin
            gnt_q   <= arb_gnt;
            write_q <= sel_write;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            send_q  <= 1'b1;
            state_q <= StIssue;
          end
        end
        StIssue: state_q <= StWaitTx;
        StWaitTx: begin
          if (bus.done_sender) begin
            if (write_q) begin
              err_q[gnt_q]  <= 1'b0;
              done_q[gnt_q] <= 1'b1;
              state_q       <= StDone;
            end else if (bus.resp_valid) begin
              // Response already back alongside the sender's done: skip the wait.
              rdata_q[gnt_q] <= bus.resp_data;
              err_q[gnt_q]   <= 1'b0;
              done_q[gnt_q]  <= 1'b1;
              state_q        <= StDone;
            end else begin
              ctr_q   <= '0;
              state_q <= StWaitResp;
            end
          end
        end
        StWaitResp: begin
          if (bus.resp_valid) begin
            rdata_q[gnt_q] <= bus.resp_data;
            err_q[gnt_q]   <= 1'b0;
            done_q[gnt_q]  <= 1'b1;
            state_q        <= StDone;
          end else if (ctr_q == CTR_MAX) begin
            rdata_q[gnt_q] <= ERR_DATA;
            err_q[gnt_q]   <= 1'b1;
            done_q[gnt_q]  <= 1'b1;
            state_q        <= StDone;
          end else begin
            ctr_q <= ctr_q + 1'b1;
          end
        end
        StDone: begin
          rr_ptr_q <= ~gnt_q;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.send       = send_q;
  assign bus.link_write = write_q;
  assign bus.link_addr  = addr_q;
  assign bus.link_wdata = wdata_q;
  assign bus.req0_done  = done_q[0];
  assign bus.req1_done  = done_q[1];
  assign bus.req0_err   = err_q[0];
  assign bus.req1_err   = err_q[1];
  assign bus.req0_rdata = rdata_q[0];
  assign bus.req1_rdata = rdata_q[1];
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_mem_link_arbiter.sv
// Bench for mem_link_arbiter: directed scenarios plus randomized traffic against a transaction model.
module tb_mem_link_arbiter;
  import mem_link_arbiter_pkg::*;

  localparam int unsigned AW   = DEF_ADDR_W;
  localparam int unsigned DW   = DEF_DATA_W;
  localparam int unsigned TO   = 12;
  localparam logic [DW-1:0] ERRD = 32'hDEAD_BEEF;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_link_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_link_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .TIMEOUT  (TO),
    .ERR_DATA (ERRD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Requester intent and expected outcomes, kept at transaction level.
  bit          p_rd    [2];
  bit          p_wr    [2];
  logic [AW-1:0] p_addr  [2];
  logic [DW-1:0] p_wdata [2];
  int          m_ptr;
  logic [DW-1:0] m_rdata [2];
  int          n_pass;
  int          n_checks;
  int          last_g;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    bus.req0_read  = p_rd[0];
    bus.req0_write = p_wr[0];
    bus.req0_addr  = p_addr[0];
    bus.req0_wdata = p_wdata[0];
    bus.req1_read  = p_rd[1];
    bus.req1_write = p_wr[1];
    bus.req1_addr  = p_addr[1];
    bus.req1_wdata = p_wdata[1];
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      p_rd[i] = 0; p_wr[i] = 0; p_addr[i] = '0; p_wdata[i] = '0; m_rdata[i] = '0;
    end
    m_ptr = 0;
  endtask

  function automatic logic get_done(input int i);
    return (i == 1) ? bus.req1_done : bus.req0_done;
  endfunction

  function automatic logic get_err(input int i);
    return (i == 1) ? bus.req1_err : bus.req0_err;
  endfunction

  function automatic logic [DW-1:0] get_rdata(input int i);
    return (i == 1) ? bus.req1_rdata : bus.req0_rdata;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    clear_model();
    apply();
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Runs one granted transaction acting as sender (done after d cycles) and receiver
  // (response r cycles after done_sender; r=0 coincident, r>TO never arrives).
  task automatic serve(input int d, input int r, input int exp_lat, input bit cont,
                       input logic [DW-1:0] rd);
    int g, n, e;
    bit wr, extra;
    logic [DW-1:0] exp_rd;
    logic exp_err;
    if ((p_rd[0] | p_wr[0]) && (p_rd[1] | p_wr[1])) g = m_ptr;
    else g = (p_rd[1] | p_wr[1]) ? 1 : 0;
    wr = p_wr[g];
    n = 0;
    while (bus.send !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("send_latency", n, exp_lat);
    if (bus.send !== 1'b1) return;
    chk("busy_issue", bus.busy, 1);
    chk("link_write", bus.link_write, wr);
    chk("link_addr", bus.link_addr, p_addr[g]);
    chk("link_wdata", bus.link_wdata, p_wdata[g]);
    // Disturb the granted requester's inputs; the link must keep the latched values.
    if (g == 0) begin
      bus.req0_addr = ~p_addr[0]; bus.req0_wdata = ~p_wdata[0];
    end else begin
      bus.req1_addr = ~p_addr[1]; bus.req1_wdata = ~p_wdata[1];
    end
    extra = 0;
    for (int i = 0; i < d; i++) begin
      tick();
      if (bus.send !== 1'b0 || bus.req0_done !== 1'b0 || bus.req1_done !== 1'b0) extra = 1;
    end
    chk("single_send_no_done", extra, 0);
    chk("link_addr_held", bus.link_addr, p_addr[g]);
    chk("link_wdata_held", bus.link_wdata, p_wdata[g]);
    apply();
    bus.done_sender = 1'b1;
    if (!wr && r == 0) begin
      bus.resp_valid = 1'b1;
      bus.resp_data  = rd;
    end
    tick();
    bus.done_sender = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_data   = $urandom;
    e = wr ? 0 : ((r <= int'(TO)) ? r : int'(TO));
    extra = 0;
    for (int i = 1; i <= e; i++) begin
      if (bus.req0_done !== 1'b0 || bus.req1_done !== 1'b0) extra = 1;
      if (i == r) begin
        bus.resp_valid = 1'b1;
        bus.resp_data  = rd;
      end
      tick();
      bus.resp_valid = 1'b0;
      bus.resp_data  = $urandom;
    end
    chk("no_early_done", extra, 0);
    if (wr) begin
      exp_rd = m_rdata[g]; exp_err = 1'b0;
    end else if (r <= int'(TO)) begin
      exp_rd = rd; exp_err = 1'b0;
    end else begin
      exp_rd = ERRD; exp_err = 1'b1;
    end
    chk("done_granted", get_done(g), 1);
    chk("done_other", get_done(1 - g), 0);
    chk("rdata", get_rdata(g), exp_rd);
    chk("err", get_err(g), exp_err);
    chk("rdata_other_held", get_rdata(1 - g), m_rdata[1 - g]);
    last_g = bus.req1_done ? 1 : 0;
    m_rdata[g] = exp_rd;
    m_ptr = 1 - g;
    if (!cont) begin
      p_rd[g] = 0;
      p_wr[g] = 0;
      apply();
    end
    tick();
    chk("done_is_pulse", {bus.req0_done, bus.req1_done}, 0);
    chk("busy_after_done", bus.busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bit bad;
    n_pass = 0;
    n_checks = 0;
    last_g = 0;
    clear_model();
    apply();
    bus.done_sender = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_data   = '0;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_send", bus.send, 0);
    chk("rst_link", {bus.link_write, bus.link_addr, bus.link_wdata}, 0);
    chk("rst_done", {bus.req0_done, bus.req1_done}, 0);
    chk("rst_err", {bus.req0_err, bus.req1_err}, 0);
    chk("rst_rdata0", bus.req0_rdata, 0);
    chk("rst_rdata1", bus.req1_rdata, 0);
    reset = 1'b0;
    tick();

    // Single write from requester 0.
    p_wr[0] = 1; p_addr[0] = 10'h015; p_wdata[0] = 32'h1234_5678; apply();
    serve(5, 0, 1, 0, 32'h0);

    // Single read from requester 1, response 4 cycles after done_sender.
    p_rd[1] = 1; p_addr[1] = 10'h3FF; p_wdata[1] = $urandom; apply();
    serve(3, 4, 1, 0, 32'hCAFE_0001);

    // Both writing continuously from reset: grants alternate 0,1,0,1.
    do_reset();
    p_wr[0] = 1; p_addr[0] = 10'h0A5; p_wdata[0] = $urandom;
    p_wr[1] = 1; p_addr[1] = 10'h15A; p_wdata[1] = $urandom;
    apply();
    for (int i = 0; i < 4; i++) begin
      serve($urandom_range(1, 4), 0, 1, 1, $urandom);
      chk("alternate_order", last_g, i % 2);
    end
    clear_model();
    m_rdata[0] = bus.req0_rdata;
    m_rdata[1] = bus.req1_rdata;
    m_ptr = 0;
    apply();
    tick();
    chk("quiet_after_drop", {bus.busy, bus.send}, 0);

    // Read that never gets a response, then a stray late response.
    p_rd[0] = 1; p_addr[0] = $urandom; p_wdata[0] = $urandom; apply();
    serve(2, TO + 5, 1, 0, $urandom);
    bus.resp_valid = 1'b1; bus.resp_data = $urandom; bus.done_sender = 1'b1;
    tick();
    bus.resp_valid = 1'b0; bus.done_sender = 1'b0;
    chk("late_resp_busy", bus.busy, 0);
    chk("late_resp_done", {bus.req0_done, bus.req1_done}, 0);
    tick();
    chk("late_resp_rdata", bus.req0_rdata, ERRD);
    chk("late_resp_err", bus.req0_err, 1);

    // Response coincident with done_sender.
    p_rd[1] = 1; p_addr[1] = $urandom; p_wdata[1] = $urandom; apply();
    serve(1, 0, 1, 0, $urandom);

    // Reset pulsed during WAIT_TX.
    p_wr[0] = 1; p_addr[0] = 10'h2C3; p_wdata[0] = $urandom; apply();
    n = 0;
    while (bus.send !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("mid_rst_send_seen", bus.send, 1);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_link", {bus.send, bus.link_write, bus.link_addr, bus.link_wdata}, 0);
    chk("mid_rst_rdata", {bus.req0_rdata, bus.req1_rdata}, 0);
    chk("mid_rst_done_err", {bus.req0_done, bus.req1_done, bus.req0_err, bus.req1_err}, 0);
    clear_model();
    apply();
    tick();
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.busy !== 1'b0 || bus.req0_done !== 1'b0 || bus.req1_done !== 1'b0) bad = 1;
    end
    chk("post_rst_idle", bad, 0);
    p_rd[1] = 1; p_addr[1] = $urandom; p_wdata[1] = $urandom; apply();
    serve(2, 3, 1, 0, $urandom);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      int mask;
      int op;
      int pick;
      int r;
      mask = $urandom_range(1, 3);
      for (int i = 0; i < 2; i++) begin
        if (mask[i]) begin
          op = $urandom_range(0, 2);
          p_rd[i] = (op != 1);
          p_wr[i] = (op != 0);
          p_addr[i] = $urandom;
          p_wdata[i] = $urandom;
        end
      end
      apply();
      for (int k = 0; k < 2; k++) begin
        if (!(p_rd[0] | p_wr[0] | p_rd[1] | p_wr[1])) break;
        pick = $urandom_range(0, 9);
        if (pick < 3) r = 0;
        else if (pick < 8) r = $urandom_range(1, 6);
        else r = $urandom_range(TO - 1, TO + 3);
        serve($urandom_range(1, 6), r, 1, 0, $urandom);
      end
      for (int i = 0; i < 2; i++) begin
        p_rd[i] = 0;
        p_wr[i] = 0;
      end
      apply();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
